// File: rtl/inpkt_builder_pkg.sv
// Shared constants, FSM encoding and a width helper for the input-packet builder
// and its parser-side counterpart.
package inpkt_builder_pkg;

  function automatic int f_msb(input int value);
    int m;
    m = 0;
    for (int i = 0; i < 31; i++) begin
      if (value[i]) m = i;
    end
    return m;
  endfunction

  localparam int DEF_PKT_MAX_LEN = 16 * 65536;
  localparam int DEF_PKT_LEN_MSB = f_msb(DEF_PKT_MAX_LEN);

  localparam int HDR_LEN  = 10;
  localparam int CSUM_LEN = 4;

  localparam logic [7:0] PKT_TYPE_WORD_LIST = 8'd1;
  localparam logic [7:0] PKT_TYPE_WORD_GEN  = 8'd2;
  localparam logic [7:0] PKT_TYPE_CONFIG    = 8'd3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_CSUM,
    DATA,
    DATA_CSUM
  } state_t;

endpackage

// File: rtl/inpkt_builder_if.sv
// Command, payload-FIFO and packet-FIFO signals of the builder; master is the builder side.
interface inpkt_builder_if #(
  parameter int LEN_W = inpkt_builder_pkg::DEF_PKT_LEN_MSB + 1
) ();
  logic [7:0]       cmd_type;
  logic [LEN_W-1:0] cmd_len;
  logic [15:0]      cmd_id;
  logic             cmd_wr_en;
  logic             cmd_full;
  logic [7:0]       din;
  logic             rd_en;
  logic             empty;
  logic [7:0]       dout;
  logic             wr_en;
  logic             full;
  logic             err_cmd_len;

  modport master (
    input  cmd_type, cmd_len, cmd_id, cmd_wr_en, din, empty, full,
    output cmd_full, rd_en, dout, wr_en, err_cmd_len
  );

  modport slave (
    output cmd_type, cmd_len, cmd_id, cmd_wr_en, din, empty, full,
    input  cmd_full, rd_en, dout, wr_en, err_cmd_len
  );
endinterface

// File: rtl/inpkt_builder_csum.sv
// Running packet checksum: sums little-endian 32-bit words fed one byte at a time
// and presents the inverted sum.
module pkt_checksum_acc (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [7:0]  i_byte,
  input  logic [1:0]  i_index,
  input  logic        i_clear,
  input  logic        i_enable,
  output logic [31:0] o_csum
);
  logic [31:0] r_acc;
  logic [31:0] w_base;
  logic [31:0] w_term;

  assign w_term = {24'd0, i_byte} << {i_index, 3'b000};
  // Clear wins over the stale sum but still lets a same-cycle byte in.
  assign w_base = i_clear ? 32'd0 : r_acc;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= 32'd0;
    end else if (i_clear || i_enable) begin
      r_acc <= w_base + (i_enable ? w_term : 32'd0);
    end
  end

  assign o_csum = ~r_acc;
endmodule

// File: rtl/inpkt_builder.sv
// Frames payload bytes into header / header checksum / data / data checksum and
// streams them into a byte FIFO, one byte per cycle when not stalled.
module inpkt_builder
  import inpkt_builder_pkg::*;
#(
  parameter logic [7:0] VERSION     = 8'd2,
  parameter int         PKT_MAX_LEN = DEF_PKT_MAX_LEN,
  parameter int         PKT_LEN_MSB = f_msb(PKT_MAX_LEN)
) (
  input  logic            CLK,
  input  logic            rst_n,
  inpkt_builder_if.master bus
);
  localparam int               LEN_W       = PKT_LEN_MSB + 1;
  localparam logic [LEN_W-1:0] C_MAX_LEN   = LEN_W'(PKT_MAX_LEN);
  localparam logic [LEN_W-1:0] C_HDR_LAST  = LEN_W'(HDR_LEN - 1);
  localparam logic [LEN_W-1:0] C_CSUM_LAST = LEN_W'(CSUM_LEN - 1);
  localparam logic [LEN_W-1:0] C_ONE       = LEN_W'(1);

  state_t           r_state;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_type;
  logic [15:0]      r_id;
  logic             r_err;

  logic             w_wr;
  logic             w_rd;
  logic             w_idx_last;
  logic             w_len_bad;
  logic [23:0]      w_len24;
  logic [7:0]       w_hdr_byte;
  logic [7:0]       w_csum_byte;
  logic [31:0]      w_csum;
  logic             w_cs_clear;
  logic             w_cs_en;

  assign w_wr = (r_state != IDLE) && !bus.full && ((r_state != DATA) || !bus.empty);
  assign w_rd = (r_state == DATA) && !bus.empty && !bus.full;
  assign w_len_bad = (bus.cmd_len == '0) || (bus.cmd_len > C_MAX_LEN);
  assign w_len24 = 24'(r_len);

  always_comb begin
    w_idx_last = 1'b0;
    case (r_state)
      HDR:                 w_idx_last = (r_idx == C_HDR_LAST);
      HDR_CSUM, DATA_CSUM: w_idx_last = (r_idx == C_CSUM_LAST);
      DATA:                w_idx_last = (r_idx == (r_len - C_ONE));
      default:             w_idx_last = 1'b0;
    endcase
  end

  always_comb begin
    w_hdr_byte = 8'd0;
    case (r_idx[3:0])
      4'd0:    w_hdr_byte = VERSION;
      4'd1:    w_hdr_byte = r_type;
      4'd4:    w_hdr_byte = w_len24[7:0];
      4'd5:    w_hdr_byte = w_len24[15:8];
      4'd6:    w_hdr_byte = w_len24[23:16];
      4'd8:    w_hdr_byte = r_id[7:0];
      4'd9:    w_hdr_byte = r_id[15:8];
      default: w_hdr_byte = 8'd0;
    endcase
  end

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_csum_byte = w_csum[7:0];
      2'd1:    w_csum_byte = w_csum[15:8];
      2'd2:    w_csum_byte = w_csum[23:16];
      default: w_csum_byte = w_csum[31:24];
    endcase
  end

  // The accumulator restarts while idle and again as the header checksum finishes,
  // so each checksum covers only its own section.
  assign w_cs_clear = (r_state == IDLE) || ((r_state == HDR_CSUM) && w_wr && w_idx_last);
  assign w_cs_en    = w_wr && ((r_state == HDR) || (r_state == DATA));

  pkt_checksum_acc u_csum (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .i_byte   ((r_state == DATA) ? bus.din : w_hdr_byte),
    .i_index  (r_idx[1:0]),
    .i_clear  (w_cs_clear),
    .i_enable (w_cs_en),
    .o_csum   (w_csum)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_type  <= 8'd0;
      r_id    <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (bus.cmd_wr_en) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_len   <= bus.cmd_len;
              r_type  <= bus.cmd_type;
              r_id    <= bus.cmd_id;
              r_state <= HDR;
            end
          end
        end
        HDR, HDR_CSUM, DATA, DATA_CSUM: begin
          if (w_wr) begin
            if (w_idx_last) begin
              r_idx <= '0;
              case (r_state)
                HDR:      r_state <= HDR_CSUM;
                HDR_CSUM: r_state <= DATA;
                DATA:     r_state <= DATA_CSUM;
                default:  r_state <= IDLE;
              endcase
            end else begin
              r_idx <= r_idx + C_ONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      HDR:                 bus.dout = w_hdr_byte;
      HDR_CSUM, DATA_CSUM: bus.dout = w_csum_byte;
      DATA:                bus.dout = bus.din;
      default:             bus.dout = 8'd0;
    endcase
  end

  assign bus.wr_en       = w_wr;
  assign bus.rd_en       = w_rd;
  assign bus.cmd_full    = (r_state != IDLE);
  assign bus.err_cmd_len = r_err;
endmodule

// File: tb/tb_inpkt_builder.sv
// Scoreboard bench for inpkt_builder: directed packets with hand-computed byte streams.
module tb_inpkt_builder;
  logic clk;
  logic rst_n;

  inpkt_builder_if #(.LEN_W(21)) bus ();

  inpkt_builder dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] sb[$];

  logic [7:0] exp1 [22] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00,
                            8'h34, 8'h12, 8'hC5, 8'hEC, 8'hFF, 8'hFF,
                            8'h01, 8'h02, 8'h03, 8'h04, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
  logic [7:0] exp2 [23] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                            8'h34, 8'h12, 8'hC4, 8'hEC, 8'hFF, 8'hFF,
                            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF9, 8'hFD, 8'hFC, 8'hFB};

  // Payload FIFO model (first-word fall-through)
  logic [7:0] pay [16];
  int         pay_cnt;
  int         pay_ptr;
  logic       pay_clr;
  logic       stall_empty;

  assign bus.din   = pay[pay_ptr[3:0]];
  assign bus.empty = (pay_ptr >= pay_cnt) || stall_empty;

  always @(posedge clk) begin
    if (pay_clr) pay_ptr <= 0;
    else if (bus.rd_en) pay_ptr <= pay_ptr + 1;
  end

  // Monitor: every written byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && bus.full) begin
      n_chk++;
      if (bus.wr_en) begin
        n_fail++;
        $display("FAIL wr_en_while_full: got wr_en=1, required 0");
      end
    end
    if (bus.wr_en && !bus.full) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got %02h, required no byte", bus.dout);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (bus.dout !== e) begin
          n_fail++;
          $display("FAIL dout_byte: got %02h, required %02h", bus.dout, e);
        end else begin
          $display("byte %02h ok", bus.dout);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 1) sb.push_back(exp1[i]);
      else sb.push_back(exp2[i]);
    end
  endtask

  task automatic load_payload(input int n);
    for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
    pay_cnt = n;
    @(negedge clk);
    pay_clr = 1'b1;
    @(posedge clk);
    #1 pay_clr = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] t, input logic [20:0] len, input logic [15:0] id);
    @(negedge clk);
    bus.cmd_type  = t;
    bus.cmd_len   = len;
    bus.cmd_id    = id;
    bus.cmd_wr_en = 1'b1;
    @(posedge clk);
    #1 bus.cmd_wr_en = 1'b0;
  endtask

  // mode 0: plain, 1: toggle full, 2: 5-cycle empty gap mid-data, 3: plain without latency check
  task automatic run_pkt(input int mode, input int stop_after, output int nwr, output int ncyc);
    int gap;
    bit gap_done;
    nwr = 0;
    ncyc = 0;
    gap = 0;
    gap_done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      ncyc++;
      if (k == 0 && mode == 0) check("first_byte_latency", 32'(bus.wr_en), 32'd1);
      if (stall_empty) begin
        check("gap_wr_en", 32'(bus.wr_en), 32'd0);
        check("gap_rd_en", 32'(bus.rd_en), 32'd0);
      end
      if (bus.wr_en && !bus.full) nwr++;
      #1;
      if (stop_after > 0 && nwr == stop_after) return;
      if (sb.size() == 0) return;
      if (mode == 1) bus.full = ~bus.full;
      if (mode == 2) begin
        if (stall_empty) begin
          gap--;
          if (gap == 0) stall_empty = 1'b0;
        end else if (!gap_done && pay_ptr == 2) begin
          stall_empty = 1'b1;
          gap = 5;
          gap_done = 1'b1;
        end
      end
    end
    check("packet_timeout_bytes_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clk);
    check(name, 32'(bus.cmd_full), 32'd0);
  endtask

  initial begin
    int nwr;
    int ncyc;
    rst_n         = 1'b0;
    bus.cmd_type  = 8'd0;
    bus.cmd_len   = 21'd0;
    bus.cmd_id    = 16'd0;
    bus.cmd_wr_en = 1'b0;
    bus.full      = 1'b0;
    pay_cnt       = 0;
    pay_clr       = 1'b1;
    stall_empty   = 1'b0;
    for (int i = 0; i < 16; i++) pay[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_cmd_full", 32'(bus.cmd_full), 32'd0);
    check("reset_wr_en", 32'(bus.wr_en), 32'd0);
    check("reset_rd_en", 32'(bus.rd_en), 32'd0);
    check("reset_err_cmd_len", 32'(bus.err_cmd_len), 32'd0);
    rst_n   = 1'b1;
    pay_clr = 1'b0;

    // len=4, unstalled: 22 consecutive bytes starting the cycle after acceptance
    load_payload(4);
    push_exp(1, 22);
    issue_cmd(8'd1, 21'd4, 16'h1234);
    run_pkt(0, 0, nwr, ncyc);
    check("len4_byte_count", 32'(nwr), 32'd22);
    check("len4_consecutive_cycles", 32'(ncyc), 32'd22);
    check("cmd_full_on_last_byte", 32'(bus.cmd_full), 32'd1);
    check_idle_after("len4_idle_after");
    $display("packet len4 done: %0d bytes in %0d cycles", nwr, ncyc);

    // len=5: partial last data word
    load_payload(5);
    push_exp(2, 23);
    issue_cmd(8'd1, 21'd5, 16'h1234);
    run_pkt(0, 0, nwr, ncyc);
    check("len5_byte_count", 32'(nwr), 32'd23);
    check_idle_after("len5_idle_after");
    $display("packet len5 done: %0d bytes in %0d cycles", nwr, ncyc);

    // len=4 with full toggling every cycle
    load_payload(4);
    push_exp(1, 22);
    issue_cmd(8'd1, 21'd4, 16'h1234);
    run_pkt(1, 0, nwr, ncyc);
    bus.full = 1'b0;
    check("toggle_byte_count", 32'(nwr), 32'd22);
    check("toggle_sb_drained", 32'(sb.size()), 32'd0);
    check_idle_after("toggle_idle_after");
    $display("packet toggle-full done: %0d bytes in %0d cycles", nwr, ncyc);

    // len=4 with payload FIFO empty for 5 cycles mid-data
    load_payload(4);
    push_exp(1, 22);
    issue_cmd(8'd1, 21'd4, 16'h1234);
    run_pkt(2, 0, nwr, ncyc);
    stall_empty = 1'b0;
    check("gap_byte_count", 32'(nwr), 32'd22);
    check("gap_cycles", 32'(ncyc), 32'd27);
    check_idle_after("gap_idle_after");
    $display("packet empty-gap done: %0d bytes in %0d cycles", nwr, ncyc);

    // Bad lengths are dropped and flagged; a valid command still works
    issue_cmd(8'd1, 21'd0, 16'h1234);
    repeat (3) @(negedge clk);
    check("len0_err", 32'(bus.err_cmd_len), 32'd1);
    check("len0_cmd_full", 32'(bus.cmd_full), 32'd0);
    $display("command len=0 rejected");
    issue_cmd(8'd1, 21'h100001, 16'h1234);
    repeat (3) @(negedge clk);
    check("lenmax1_err", 32'(bus.err_cmd_len), 32'd1);
    check("lenmax1_cmd_full", 32'(bus.cmd_full), 32'd0);
    $display("command len=PKT_MAX_LEN+1 rejected");
    load_payload(5);
    push_exp(2, 23);
    issue_cmd(8'd1, 21'd5, 16'h1234);
    run_pkt(3, 0, nwr, ncyc);
    check("after_err_byte_count", 32'(nwr), 32'd23);
    check("err_sticky", 32'(bus.err_cmd_len), 32'd1);
    check_idle_after("after_err_idle");
    $display("packet after rejects done: %0d bytes", nwr);

    // Reset after header byte 5 aborts the packet immediately
    load_payload(4);
    push_exp(1, 6);
    issue_cmd(8'd1, 21'd4, 16'h1234);
    run_pkt(3, 6, nwr, ncyc);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    check("midrst_cmd_full", 32'(bus.cmd_full), 32'd0);
    check("midrst_err_cleared", 32'(bus.err_cmd_len), 32'd0);
    check("midrst_bytes_before", 32'(nwr), 32'd6);
    repeat (2) @(negedge clk);
    check("midrst_no_bytes", 32'(bus.wr_en), 32'd0);
    rst_n = 1'b1;
    $display("reset mid-packet after %0d bytes", nwr);
    load_payload(4);
    push_exp(1, 22);
    issue_cmd(8'd1, 21'd4, 16'h1234);
    run_pkt(0, 0, nwr, ncyc);
    check("post_rst_byte_count", 32'(nwr), 32'd22);
    check_idle_after("post_rst_idle");
    $display("packet after reset done: %0d bytes in %0d cycles", nwr, ncyc);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
